alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Next-generation execute-stage ALU for the ARM core.
- Width is parametrised.
- Valid/ready handshakes on input and output, with a registered result.
- Adds ARM condition flags (N, Z, C, V), an illegal-op indication, and an iterative shift-add multiplier (MUL).
- Sits between the register-read stage and writeback; the stall logic uses in_ready.

Parameters:
- WIDTH, 64, operand/result width in bits (>=8).
- CNT_W, $clog2(WIDTH), width of the multiply iteration counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  4  operation code.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- flag_n  output  1  result[WIDTH-1].
- flag_z  output  1  result == 0.
- flag_c  output  1  carry / not-borrow.
- flag_v  output  1  signed overflow.
- illegal  output  1  op not in the supported set; qualified by out_valid.

Behaviour:
- Op encodings:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a-b), 1100 NOR, 0111 PASSB, 1000 MUL (low WIDTH bits of a*b, unsigned).
  - Any other code: result=0, illegal=1, single-cycle.
- Reset: sampled only on a clk edge with rst_n=0. Effects:
  - state=IDLE, out_valid=0, result=0, all flags=0, illegal=0, counter=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Reset mid-MUL: aborts the operation; no result is ever presented for it.
- States:
  - IDLE: may accept.
  - MUL: iterating; in_ready=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational; no dependency on in_valid.
- Accept = in_valid && in_ready at a rising edge.
- Single-cycle ops: result, flags and illegal are registered at the accept edge; out_valid=1 after that edge (latency 1).
  - With out_ready held at 1, throughput is one op per cycle.
- MUL:
  - The accept edge captures a and b into internal registers, clears the accumulator, sets counter=0 and enters MUL.
  - Each following edge adds the shifted multiplicand when multiplier bit[counter]=1, then increments counter.
  - At the edge where counter==WIDTH-1: the final sum is written to result, state returns to IDLE and out_valid=1.
  - Total latency is WIDTH edges after accept. A MUL accepted at edge k presents its result after edge k+WIDTH.
- Output hold: while out_valid=1 && out_ready=0, result, flags and illegal are frozen.
- out_valid clears at an edge where out_ready=1, unless a new op is accepted at the same edge. In that case the new single-cycle result replaces the old one and out_valid stays 1.
- Flags are computed on the final result:
  - N = result[WIDTH-1].
  - Z = (result==0).
  - ADD: C = carry out of bit WIDTH-1; V = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - SUB: C = 1 when no borrow (a>=b unsigned, ARM convention); V = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
  - All other ops: C=0, V=0.
  - Arithmetic wraps modulo 2^WIDTH.
- Inputs a, b and op are ignored whenever no accept occurs. Inputs may change freely during MUL.

Decomposition:
- Package alu_pkg: opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_PASSB, OP_MUL), state encoding (ST_IDLE, ST_MUL), and the flag bit-index constants.
- Sub-module alu_mul_iter(WIDTH):
  - Holds the multiplicand/multiplier/accumulator registers and the counter.
  - Interface: start, done pulse, product.
  - Parent FSM sequences it.
- Flag and single-cycle datapath logic stays in alu_seq.

Test Plan:
- WIDTH=64, ADD a=64'hFFFF_FFFF_FFFF_FFFF, b=1, out_ready=1 -> next cycle result=0, Z=1, C=1, V=0, N=0.
- SUB a=64'h8000_0000_0000_0000, b=1 -> result=64'h7FFF_FFFF_FFFF_FFFF, V=1, C=1, N=0; then SUB a=5, b=5 -> result=0, Z=1, C=1.
- MUL a=3, b=5 accepted at edge k -> in_ready=0 for edges k+1..k+63; out_valid rises after edge k+64 with result=15; a/b toggled during MUL have no effect.
- Backpressure: AND a=F0, b=3C with out_ready=0 for 5 cycles -> result=30 held, in_ready=0 throughout; out_ready=1 -> out_valid drops next edge; back-to-back ORs then stream one per cycle.
- rst_n=0 for one edge at MUL iteration 20 -> out_valid=0, result=0, in_ready=1 next cycle; a subsequent PASSB b=7 gives result=7 after one edge.
- op=4'b1111, a=9, b=9 -> result=0, illegal=1, Z=1, C=V=0; the following valid op clears illegal.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcodes, FSM states and
// the bit positions used when flags are carried as a packed nibble.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    // Flag nibble layout: {N, Z, C, V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH
// iterations after start. Multiplicand shifts left and multiplier shifts
// right so the active multiplier bit is always bit 0.
module alu_mul_iter #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplr;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;

    assign w_addend  = r_mplr[0] ? r_mcand : '0;
    assign w_sum     = r_acc + w_addend;
    // Done is high during the last iteration; w_sum is then the final product.
    assign o_done    = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
    assign o_product = w_sum;

    // Operand capture on start, then one accumulate/shift step per clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_mplr  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else if (i_start) begin
            r_mcand <= i_a;
            r_mplr  <= i_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            r_acc   <= w_sum;
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
            if (o_done) begin
                r_cnt  <= '0;
                r_busy <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Execute-stage ALU with registered result and ARM-style N/Z/C/V flags.
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready never looks at in_valid; out_valid/result/flags/illegal are held
// stable while out_valid=1 and out_ready=0.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             illegal,
    output state_t           dbg_state
);

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic             r_illegal;

    logic             w_accept;
    logic             w_mul_start;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_product;

    logic [WIDTH:0]   w_wide;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_c;
    logic             w_sc_v;
    logic             w_sc_ill;
    logic [3:0]       w_sc_flags;
    logic [3:0]       w_mul_flags;

    assign in_ready    = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (op == OP_MUL);

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_n    = r_flags[FLAG_N];
    assign flag_z    = r_flags[FLAG_Z];
    assign flag_c    = r_flags[FLAG_C];
    assign flag_v    = r_flags[FLAG_V];
    assign illegal   = r_illegal;
    assign dbg_state = r_state;

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_start),
        .i_a       (a),
        .i_b       (b),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    // Single-cycle datapath: result, carry/overflow and illegal-op decode.
    always_comb begin
        w_wide   = '0;
        w_sc_res = '0;
        w_sc_c   = 1'b0;
        w_sc_v   = 1'b0;
        w_sc_ill = 1'b0;
        case (op)
            OP_AND:   w_sc_res = a & b;
            OP_OR:    w_sc_res = a | b;
            OP_NOR:   w_sc_res = ~(a | b);
            OP_PASSB: w_sc_res = b;
            OP_ADD: begin
                w_wide   = {1'b0, a} + {1'b0, b};
                w_sc_res = w_wide[WIDTH-1:0];
                w_sc_c   = w_wide[WIDTH];
                w_sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sc_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is the borrow; C is its inverse.
                w_wide   = {1'b0, a} - {1'b0, b};
                w_sc_res = w_wide[WIDTH-1:0];
                w_sc_c   = ~w_wide[WIDTH];
                w_sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sc_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL:   w_sc_ill = 1'b0;
            default:  w_sc_ill = 1'b1;
        endcase
    end

    // Pack flags for both result sources; MUL never sets C or V.
    always_comb begin
        w_sc_flags          = '0;
        w_sc_flags[FLAG_N]  = w_sc_res[WIDTH-1];
        w_sc_flags[FLAG_Z]  = (w_sc_res == '0);
        w_sc_flags[FLAG_C]  = w_sc_c;
        w_sc_flags[FLAG_V]  = w_sc_v;
        w_mul_flags         = '0;
        w_mul_flags[FLAG_N] = w_product[WIDTH-1];
        w_mul_flags[FLAG_Z] = (w_product == '0);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: leave IDLE on a MUL accept, return when the multiplier finishes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_mul_start) w_state_nxt = ST_MUL;
            ST_MUL:  if (w_mul_done)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output register: load on single-cycle accept or MUL completion,
    // otherwise drop valid once the consumer takes the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_illegal   <= 1'b0;
        end else if (w_accept && (op != OP_MUL)) begin
            r_out_valid <= 1'b1;
            r_result    <= w_sc_res;
            r_flags     <= w_sc_flags;
            r_illegal   <= w_sc_ill;
        end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_product;
            r_flags     <= w_mul_flags;
            r_illegal   <= 1'b0;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=64: a table of single-cycle vectors
// streamed back to back, plus hand-written MUL, backpressure and reset cases.
module tb_alu_seq;

  localparam int W = 64;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   nzcv;
    logic         ill;
  } vec_t;

  localparam int NVEC = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         flag_n, flag_z, flag_c, flag_v, illegal;
  alu_pkg::state_t dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[NVEC];
  logic [W-1:0] exp_q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard compare
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {flag_n, flag_z, flag_c, flag_v};
  endfunction

  // driver
  task automatic drive(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
    op = o;
    a = va;
    b = vb;
    in_valid = 1'b1;
  endtask

  // MUL: accept, check busy for 64 sampled cycles while scrambling inputs, then result.
  task automatic run_mul(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] exp_res, input logic [3:0] exp_flags);
    logic busy_err;
    logic state_err;
    @(negedge clk);
    out_ready = 1'b1;
    drive(4'b1000, va, vb);
    check({name, " in_ready at accept"}, W'(in_ready), W'(1));
    @(posedge clk);
    busy_err = 1'b0;
    state_err = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      in_valid = (i % 3) == 0;
      op = 4'b0010;
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_err = 1'b1;
      if (dbg_state !== alu_pkg::ST_MUL) state_err = 1'b1;
      @(posedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check({name, " busy window"}, W'(busy_err), W'(0));
    check({name, " debug state"}, W'(state_err), W'(0));
    check({name, " out_valid"}, W'(out_valid), W'(1));
    check({name, " result"}, result, exp_res);
    check({name, " flags"}, W'(flags_now()), W'(exp_flags));
    check({name, " illegal"}, W'(illegal), W'(0));
    check({name, " in_ready after"}, W'(in_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    check({name, " out_valid drop"}, W'(out_valid), W'(0));
  endtask

  initial begin
    logic seen_valid;
    logic [W-1:0] e;

    //                op       a                        b                        result                   nzcv    ill
    vecs[0]  = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                   64'd0,                   4'b0110, 1'b0};
    vecs[1]  = '{4'b0110, 64'h8000_0000_0000_0000, 64'd1,                   64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b0};
    vecs[2]  = '{4'b0110, 64'd5,                   64'd5,                   64'd0,                   4'b0110, 1'b0};
    vecs[3]  = '{4'b0110, 64'd3,                   64'd5,                   64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0};
    vecs[4]  = '{4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                   64'h8000_0000_0000_0000, 4'b1001, 1'b0};
    vecs[5]  = '{4'b0000, 64'hF0,                  64'h3C,                  64'h30,                  4'b0000, 1'b0};
    vecs[6]  = '{4'b0001, 64'hF0,                  64'h0F,                  64'hFF,                  4'b0000, 1'b0};
    vecs[7]  = '{4'b1100, 64'd0,                   64'd0,                   64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0};
    vecs[8]  = '{4'b0111, 64'h123,                 64'hAB,                  64'hAB,                  4'b0000, 1'b0};
    vecs[9]  = '{4'b1111, 64'd9,                   64'd9,                   64'd0,                   4'b0100, 1'b1};
    vecs[10] = '{4'b0010, 64'd2,                   64'd3,                   64'd5,                   4'b0000, 1'b0};
    vecs[11] = '{4'b0011, 64'd7,                   64'd7,                   64'd0,                   4'b0100, 1'b1};
    vecs[12] = '{4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   64'd0,                   4'b0100, 1'b0};
    vecs[13] = '{4'b0110, 64'd0,                   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'b1001, 1'b0};
    vecs[14] = '{4'b0010, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0,                   4'b0111, 1'b0};

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", W'(out_valid), W'(0));
    check("reset result", result, W'(0));
    check("reset flags", W'(flags_now()), W'(0));
    check("reset illegal", W'(illegal), W'(0));
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready after reset", W'(in_ready), W'(1));

    // table: streamed one per cycle with out_ready high
    out_ready = 1'b1;
    drive(vecs[0].op, vecs[0].a, vecs[0].b);
    exp_q.push_back(vecs[0].res);
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("vec%0d out_valid", i), W'(out_valid), W'(1));
      check($sformatf("vec%0d result", i), result, e);
      check($sformatf("vec%0d flags", i), W'(flags_now()), W'(vecs[i].nzcv));
      check($sformatf("vec%0d illegal", i), W'(illegal), W'(vecs[i].ill));
      check($sformatf("vec%0d in_ready", i), W'(in_ready), W'(1));
      if (i + 1 < NVEC) begin
        drive(vecs[i+1].op, vecs[i+1].a, vecs[i+1].b);
        exp_q.push_back(vecs[i+1].res);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("table drain out_valid", W'(out_valid), W'(0));

    // MUL cases
    run_mul("mul 3x5", 64'd3, 64'd5, 64'd15, 4'b0000);
    run_mul("mul wide", 64'h0000_0001_0000_0003, 64'h0000_0000_0001_0005,
            64'h0001_0005_0003_000F, 4'b0000);
    run_mul("mul ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000);
    run_mul("mul msb", 64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'b1000);
    run_mul("mul zero", 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd0, 4'b0100);

    // backpressure: AND held for 5 cycles, a competing OR must not be taken
    @(negedge clk);
    out_ready = 1'b0;
    drive(4'b0000, 64'hF0, 64'h3C);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(4'b0001, 64'd1, 64'd2);
      check($sformatf("bp%0d out_valid", i), W'(out_valid), W'(1));
      check($sformatf("bp%0d result", i), result, 64'h30);
      check($sformatf("bp%0d in_ready", i), W'(in_ready), W'(0));
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", W'(in_ready), W'(1));
    check("bp release result", result, 64'h30);
    @(posedge clk);
    @(negedge clk);
    check("bp release out_valid", W'(out_valid), W'(0));

    // back-to-back ORs
    drive(4'b0001, 64'h100, 64'd0);
    exp_q.push_back(64'h100);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("or%0d out_valid", j), W'(out_valid), W'(1));
      check($sformatf("or%0d result", j), result, e);
      if (j < 3) begin
        drive(4'b0001, W'(j + 2) << 8, W'(j + 1));
        exp_q.push_back((W'(j + 2) << 8) | W'(j + 1));
      end else begin
        in_valid = 1'b0;
      end
    end

    // reset in the middle of a MUL
    @(negedge clk);
    drive(4'b1000, 64'd3, 64'd5);
    @(posedge clk);
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midmul reset out_valid", W'(out_valid), W'(0));
    check("midmul reset result", result, W'(0));
    check("midmul reset flags", W'(flags_now()), W'(0));
    check("midmul reset in_ready", W'(in_ready), W'(1));
    drive(4'b0111, 64'd0, 64'd7);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("passb after reset out_valid", W'(out_valid), W'(1));
    check("passb after reset result", result, 64'd7);
    seen_valid = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b0) seen_valid = 1'b1;
    end
    check("aborted mul never presented", W'(seen_valid), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
